// File: rtl/mux_scan_if.sv
// mux_scan_if -- channel-mux bus bundle for mux_scan.
//   din  : N*W packed channel data, channel k at [k*W +: W]
//   sel  : manual channel select
//   mode : 0 = manual, 1 = auto-scan
//   hold : freezes the auto-scan position
//   dout : registered selected channel data
//   ch   : registered index of the channel driving dout
//   tick : one-cycle pulse on each auto-scan advance
//   err  : registered out-of-range select flag (manual mode)
// master drives the inputs (testbench/host side), slave is the mux.
interface mux_scan_if #(
  parameter int N = 4,
  parameter int W = 2
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           hold;
  logic [W-1:0]   dout;
  logic [SW-1:0]  ch;
  logic           tick;
  logic           err;

  modport master (
    output din, sel, mode, hold,
    input  dout, ch, tick, err
  );

  modport slave (
    input  din, sel, mode, hold,
    output dout, ch, tick, err
  );
endinterface

// File: rtl/mux_scan.sv
// mux_scan -- registered N-channel multiplexer with manual select and
// timed auto-scan.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mux_scan_if slave (din/sel/mode/hold in, dout/ch/tick/err out)
// The FSM state is mode registered each edge; behaviour on an edge is
// decided by the state held before that edge.
module mux_scan #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int DWELL = 4
) (
  input  logic      clk,
  input  logic      rst,
  mux_scan_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   N_EXT    = (SW+1)'(N);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          sel_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MANUAL;
    else     state_q <= state_d;
  end

  // Next state simply follows mode
  always_comb begin
    state_d = bus.mode ? AUTO : MANUAL;
  end

  assign sel_ok = {1'b0, bus.sel} < N_EXT;

  // Output / datapath next-state logic
  always_comb begin
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      MANUAL: begin
        cnt_d = '0;
        if (sel_ok) ch_d = bus.sel;
        else        err_d = 1'b1;
      end
      AUTO: begin
        if (!bus.hold) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // dout is taken from the channel being registered this edge, so dout
    // and ch always refer to the same channel
    dout_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ch_d == SW'(k)) dout_d = bus.din[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.ch   = ch_q;
  assign bus.tick = tick_q;
  assign bus.err  = err_q;
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range N>=2.
REQ-002 SHALL have parameter W, default 2: bits per channel, legal range W>=1.
REQ-003 SHALL have parameter DWELL, default 4: clock cycles spent on each channel in auto mode, legal range DWELL>=1.
REQ-004 SHALL define SW = max(1, ceil(log2 N)) as the select/index width.
REQ-005 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port din  input  N*W: channel k occupies bits [k*W+W-1 : k*W].
REQ-008 SHALL have port sel  input  SW: manual channel select.
REQ-009 SHALL have port mode  input  1: 0 = manual, 1 = auto-scan.
REQ-010 SHALL have port hold  input  1: freezes the auto-scan position.
REQ-011 SHALL have port dout  output  W: registered selected channel data.
REQ-012 SHALL have port ch  output  SW: registered index of the channel driving dout.
REQ-013 SHALL have port tick  output  1: one-cycle pulse on each auto-scan advance.
REQ-014 SHALL have port err  output  1: registered flag, sel out of range in manual mode.

Function
REQ-015 SHALL implement a two-state FSM, MANUAL and AUTO, whose next state equals mode sampled at each edge.
REQ-016 SHALL compute ch_next per cycle, then register ch <= ch_next and dout <= din[ch_next*W +: W] on the same edge, so dout and ch are always consistent.
REQ-017 SHALL give 1-cycle latency from a change on sel or din to the corresponding dout.
REQ-018 SHALL, in MANUAL with sel < N: set ch_next = sel, and register err <= 0.
REQ-019 SHALL, in MANUAL with sel >= N (only possible when N is not a power of 2): set ch_next = ch (held), and register err <= 1.
REQ-020 SHALL hold a dwell counter cnt (width ceil(log2 DWELL) or 1), cleared to 0 in MANUAL.
REQ-021 SHALL, in AUTO with hold=0 and cnt < DWELL-1: increment cnt and keep ch_next = ch.
REQ-022 SHALL, in AUTO with hold=0 and cnt = DWELL-1: clear cnt, set ch_next = ch+1 (wrapping N-1 -> 0), and register tick <= 1.
REQ-023 SHALL register tick <= 0 in every other case.
REQ-024 SHALL, in AUTO with hold=1: freeze cnt and ch, keep tick = 0, and continue to refresh dout from live din[ch].
REQ-025 SHALL, when DWELL=1, advance one channel every cycle in AUTO with hold=0.
REQ-026 SHALL, on a MANUAL->AUTO transition: start from the current ch with cnt = 0, so the first advance occurs DWELL cycles after the first AUTO cycle.
REQ-027 SHALL, on an AUTO->MANUAL transition: apply sel on the first MANUAL edge and ignore hold.
REQ-028 SHALL keep err at 0 in AUTO and clear it on the first AUTO edge.
REQ-029 SHALL ignore hold in MANUAL.

Reset
REQ-030 SHALL, on the edge with rst=1, set dout=0, ch=0, cnt=0, tick=0, err=0, and FSM=MANUAL, overriding all other inputs including mid-scan and with hold=1.
REQ-031 SHALL, on the first edge after rst deasserts, behave per mode, sel and din from that edge onward.

Verification (N=4, W=2, DWELL=4 unless stated)
REQ-032 SHALL cover manual select: din=8'b11_10_01_00, mode=0, sel stepped 0..3 -> dout 00, 01, 10, 11 one cycle after each sel, ch = sel, err=0.
REQ-033 SHALL cover auto scan with wrap: mode=1 held for 20 cycles -> ch sequence 0,0,0,0,1,1,1,1,2..3,3,3,3,0; tick high once every 4 cycles, coincident with each ch change, including 3->0.
REQ-034 SHALL cover hold: hold=1 for 6 cycles at cnt=2 on ch=1 -> ch stays 1 and tick stays 0; din[3:2] toggled during hold -> dout follows after 1 cycle; after hold drops, ch->2 exactly 2 cycles later.
REQ-035 SHALL cover the out-of-range select: N=3, W=2, ch=1, sel=3 -> ch stays 1, err=1 next cycle; sel=2 -> ch=2, err=0.
REQ-036 SHALL cover reset mid-scan: rst=1 at ch=2, cnt=3, hold=1 -> next cycle dout=0, ch=0, tick=0, err=0; with mode=1 after release, first tick occurs 4 cycles later.
REQ-037 SHALL cover DWELL=1 with mode=1 -> ch 0,1,2,3,0 on consecutive cycles with tick high every cycle.
